// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions used by the I2S transmitter and its neighbours.
//   I2S_SAMPLE_W_DEFAULT  default bits per channel slot
//   I2S_BCLK_DIV_DEFAULT  default core clocks per BCLK half-period
//   slot_t                word-select encoding (SLOT_LEFT=0, SLOT_RIGHT=1)
//   stereo_sample_t       {left, right} pair at the default width
//   slot_of_idx()         which slot a frame bit index belongs to
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int I2S_SAMPLE_W_DEFAULT = 16;
  localparam int I2S_BCLK_DIV_DEFAULT = 2;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_t;

  typedef struct packed {
    logic [I2S_SAMPLE_W_DEFAULT-1:0] left;
    logic [I2S_SAMPLE_W_DEFAULT-1:0] right;
  } stereo_sample_t;

  // The first half of a frame is the left slot, the second half the right slot
  function automatic slot_t slot_of_idx(input int idx, input int sample_w);
    return (idx >= sample_w) ? SLOT_RIGHT : SLOT_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if
// Sample handshake between a PCM producer and the I2S transmitter.
//   left_in, right_in  stereo pair, two's complement
//   sample_valid       producer has a pair on left_in/right_in
//   sample_ready       transmitter holding register is empty
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface i2s_tx_if #(
  parameter int SAMPLE_W = audio_pkg::I2S_SAMPLE_W_DEFAULT
);

  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output left_in,
    output right_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// -----------------------------------------------------------------------------
// i2s_bclk_gen
// Divides the core clock down to the I2S bit clock.
//   clock      core clock, posedge
//   reset      asynchronous, active-high
//   enable     low holds the divider cleared and bclk low
//   bclk       registered bit clock, toggles every BCLK_DIV enabled clocks
//   rise_tick  strobe in the clock where bclk goes 0->1
//   fall_tick  strobe in the clock where bclk goes 1->0
// The first tick after enable always raises bclk.
// -----------------------------------------------------------------------------
module i2s_bclk_gen #(
  parameter int BCLK_DIV = audio_pkg::I2S_BCLK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  // Strobes are combinational so the framing logic reacts in the same clock
  // that the bclk register toggles
  assign tick      = enable && (div_cnt == CNT_LAST);
  assign rise_tick = tick && !bclk;
  assign fall_tick = tick && bclk;

  // Divider counts enabled clocks; each terminal count toggles bclk.
  // Dropping enable returns everything to the reset state so a restart
  // begins with a full half-period followed by a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= !bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// I2S master transmitter. Accepts stereo PCM pairs over a valid/ready
// handshake, generates BCLK/LRCK from the core clock and shifts the samples
// out MSB first with the standard one-bit I2S delay.
//   clock            PLL core clock, posedge
//   reset            asynchronous, active-high
//   enable           tie to PLL locked; low idles with outputs at reset values
//   sample_if        slave side of i2s_tx_if (left_in, right_in,
//                    sample_valid, sample_ready)
//   bclk             registered bit clock
//   lrck             registered word select (0 left slot, 1 right slot)
//   sdata            registered serial data, changes with bclk 1->0
//   underflow        1-clock pulse when a frame starts with nothing held
//   underflow_count  [7:0] saturating underflow count, only when the macro
//                    I2S_TX_UNDERFLOW_CNT_EN is defined (cleared by reset only)
// -----------------------------------------------------------------------------
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W_DEFAULT,
  parameter int BCLK_DIV = I2S_BCLK_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  i2s_tx_if.slave    sample_if,
  output logic       bclk,
  output logic       lrck,
  output logic       sdata,
  output logic       underflow
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  ,
  output logic [7:0] underflow_count
`endif
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int IDX_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

  logic               bclk_rise;
  logic               bclk_fall;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] hold_data;
  logic               hold_valid;
  logic               accept;
  logic               frame_load;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .bclk      (bclk),
    .rise_tick (bclk_rise),
    .fall_tick (bclk_fall)
  );

  // The two strobes come from opposite bclk levels and can never coincide
  assert property (@(posedge clock) disable iff (reset) !(bclk_rise && bclk_fall));

  // Ready is simply "holding register empty", so it never depends on valid
  // in the same clock; a new pair is only taken while the transmitter runs
  assign sample_if.sample_ready = !hold_valid;
  assign accept     = enable && sample_if.sample_valid && !hold_valid;
  assign frame_load = bclk_fall && (idx == IDX_LAST);
  assign idx_next   = frame_load ? '0 : idx + 1'b1;

  // Framing: on every bclk falling edge the bit index advances and lrck and
  // sdata move with it. frame_q holds the whole {left,right} word and the
  // outgoing bit is picked by the old index, which yields the one-bit delay:
  // the bit sent at new index k is word bit FRAME_W-k, and at the wrap it is
  // bit 0 of the frame just finished (its right LSB) before the next word is
  // loaded from the holding register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      lrck      <= SLOT_LEFT;
      sdata     <= 1'b0;
      frame_q   <= '0;
      underflow <= 1'b0;
    end else if (!enable) begin
      idx       <= '0;
      lrck      <= SLOT_LEFT;
      sdata     <= 1'b0;
      frame_q   <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (bclk_fall) begin
        idx   <= idx_next;
        lrck  <= slot_of_idx(32'(idx_next), SAMPLE_W);
        sdata <= frame_q[IDX_LAST - idx];
        if (frame_load) begin
          frame_q   <= hold_valid ? hold_data : '0;
          underflow <= !hold_valid;
        end
      end
    end
  end

  // Holding register: one pair deep. A frame load frees it unless a new
  // pair is captured in that same clock, in which case it stays full.
  // Disabling drops whatever was held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (!enable) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= {sample_if.left_in, sample_if.right_in};
    end else if (frame_load) begin
      hold_valid <= 1'b0;
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [7:0] underflow_cnt_q;

  // Saturating count of underflow pulses; survives enable drops so the
  // total starvation history is visible until the next reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow_cnt_q <= 8'h00;
    end else if (underflow && (underflow_cnt_q != 8'hFF)) begin
      underflow_cnt_q <= underflow_cnt_q + 8'h01;
    end
  end

  assign underflow_count = underflow_cnt_q;
`endif

endmodule
